cell_sweep: RTL

CELL_SWEEP -- requirements
Module: cell_sweep

---
 rtl/cell_sweep_pkg.sv | 26 ++
 rtl/cell_sweep.sv | 118 +++++++++++
 2 files changed

// File: rtl/cell_sweep_pkg.sv
// Shared definitions for the cell sweep engine and the game-of-life grid it
// walks: default operand width, grid constants and the sweep FSM encoding.
package cell_sweep_pkg;

    // Default width of indices, row/col coordinates and divider operands.
    localparam int CS_W_DEFAULT = 8;

    // Game-of-life grid geometry used by the surrounding engine.
    localparam int GOL_ROWS  = 16;
    localparam int GOL_COLS  = 16;
    localparam int GOL_CELLS = GOL_ROWS * GOL_COLS;

    // Sweep FSM encoding, also exported on the debug state port.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_HOLD  = 2'd2,
        S_FIN   = 2'd3
    } sweep_state_t;

    // A sweep is in progress in every state except IDLE.
    function automatic logic state_is_busy(input sweep_state_t st);
        return st != S_IDLE;
    endfunction

endpackage

// File: rtl/cell_sweep.sv
// Walks linear cell indices 0..count-1 of a grid that is `cols` cells wide and
// emits (row, col, index) for each, using an external combinational divider
// for index / cols. One coordinate every two cycles without backpressure.
//
// Output handshake: a coordinate transfers on a rising edge where out_valid
// and out_ready are both 1. Once out_valid rises, out_row/out_col/out_index
// stay stable until that transfer; out_valid never drops without a transfer.
module cell_sweep
    import cell_sweep_pkg::*;
#(
    parameter int W = CS_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] cols_cfg,
    input  logic [W-1:0] count_cfg,
    output logic [W-1:0] div_num,
    output logic [W-1:0] div_den,
    input  logic [W-1:0] div_quo,
    input  logic [W-1:0] div_rem,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_row,
    output logic [W-1:0] out_col,
    output logic [W-1:0] out_index,
    output logic         busy,
    output logic         done,
    output logic         cfg_err,
    output logic [1:0]   dbg_state
);

    sweep_state_t state;
    logic [W-1:0] cnt;   // latched cell count, always >= 1 while sweeping
    logic [W-1:0] idx;   // current linear index, never exceeds cnt-1

    // Last index of the sweep; cnt is nonzero whenever this is consulted.
    logic [W-1:0] last_idx;
    assign last_idx = cnt - W'(1);

    assign dbg_state = state;

    // Sweep controller: all state and registered outputs in one block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            idx       <= '0;
            div_num   <= '0;
            div_den   <= '0;
            out_valid <= 1'b0;
            out_row   <= '0;
            out_col   <= '0;
            out_index <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (cols_cfg == '0) begin
                            // A zero-width grid cannot be divided; flag and stay.
                            cfg_err <= 1'b1;
                        end else if (count_cfg == '0) begin
                            // Nothing to sweep: go straight to completion.
                            state <= S_FIN;
                            busy  <= 1'b1;
                        end else begin
                            cnt     <= count_cfg;
                            idx     <= '0;
                            div_num <= '0;
                            div_den <= cols_cfg;
                            cfg_err <= 1'b0;
                            busy    <= 1'b1;
                            state   <= S_ISSUE;
                        end
                    end
                end

                S_ISSUE: begin
                    // Divider operands were set up on entry; capture its result.
                    out_row   <= div_quo;
                    out_col   <= div_rem;
                    out_index <= idx;
                    out_valid <= 1'b1;
                    state     <= S_HOLD;
                end

                S_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (idx == last_idx) begin
                            state <= S_FIN;
                        end else begin
                            idx     <= idx + W'(1);
                            div_num <= idx + W'(1);
                            state   <= S_ISSUE;
                        end
                    end
                end

                S_FIN: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
